// File: rtl/phy_symbols_pkg.sv
// PHY symbol codes, receive FSM state encoding and FIFO entry layout shared by
// the demux, the deframer and their testbenches.
package phy_symbols_pkg;

    localparam logic [7:0] SYM_DATA = 8'h00;
    localparam logic [7:0] SYM_STP  = 8'hfb;
    localparam logic [7:0] SYM_SDP  = 8'h5c;
    localparam logic [7:0] SYM_END  = 8'hfd;
    localparam logic [7:0] SYM_EDB  = 8'hfe;
    localparam logic [7:0] SYM_SKP  = 8'h1c;
    localparam logic [7:0] SYM_IDL  = 8'h7c;
    localparam logic [7:0] SYM_FTS  = 8'h3c;
    localparam logic [7:0] SYM_COM  = 8'hbc;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TLP  = 2'd1,
        ST_DLLP = 2'd2
    } rx_state_e;

    // Entry layout: {type, last, byte}
    localparam int ENTRY_W  = 10;
    localparam int LAST_BIT = 8;
    localparam int TYPE_BIT = 9;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic typ, input logic last,
                                                      input logic [7:0] b);
        return {typ, last, b};
    endfunction

endpackage

// File: rtl/rx_pkt_fifo.sv
// Packet FIFO with a speculative write pointer: bytes become readable only
// once committed, and an aborted packet is discarded by rewinding to commit.
module rx_pkt_fifo
    import phy_symbols_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               wr_en_i,
    input  logic [ENTRY_W-1:0] wr_entry_i,
    input  logic               commit_i,
    input  logic               rewind_i,
    input  logic               rd_en_i,
    output logic               full_o,
    output logic               rd_valid_o,
    output logic [ENTRY_W-1:0] rd_entry_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]      wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [PW-1:0]      wr_prev;
    logic               wr_fire;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    assign wr_prev    = wr_q - PW'(1);
    assign full_o     = (wr_q - rd_q) == PW'(DEPTH);
    assign wr_fire    = wr_en_i && !full_o && !rewind_i;
    assign rd_valid_o = rd_q != cm_q;
    // Masked so nothing stale or uninitialised leaks out while empty.
    assign rd_entry_o = rd_valid_o ? mem_q[rd_q[AW-1:0]] : '0;

    always_comb begin
        wr_d = wr_q;
        if (rewind_i) begin
            wr_d = cm_q;
        end else if (wr_fire) begin
            wr_d = wr_q + PW'(1);
        end
        cm_d = commit_i ? wr_q : cm_q;
        rd_d = (rd_en_i && rd_valid_o) ? rd_q + PW'(1) : rd_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            cm_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            cm_q <= cm_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_q[AW-1:0]] <= wr_entry_i;
        end
        if (commit_i) begin
            mem_q[wr_prev[AW-1:0]][LAST_BIT] <= 1'b1;
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: strips STP/SDP...END framing, buffers each packet until
// END commits it, and drops malformed packets with a one-cycle pkt_err pulse.
module rx_deframer
    import phy_symbols_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int MAX_LEN = 16
) (
    input  logic      clk_250k,
    input  logic      reset,
    input  logic      valid,
    input  logic [7:0] control,
    input  logic [7:0] data_dm,
    output logic      out_valid,
    input  logic      out_ready,
    output logic [7:0] out_data,
    output logic      out_last,
    output logic      out_type,
    output logic      pkt_err,
    output logic [7:0] pkt_count,
    output logic [7:0] err_count,
    output rx_state_e dbg_state_o
);

    localparam int LW = $clog2(MAX_LEN + 1);

    rx_state_e          state_q;
    logic [LW-1:0]      len_q;
    logic               pkt_err_q;
    logic [7:0]         pkt_cnt_q;
    logic [7:0]         err_cnt_q;

    logic               do_write, do_commit, do_drop;
    logic               fifo_full;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Inside a packet every symbol other than an accepted data byte or a
    // non-empty END aborts it; the aborting symbol itself is consumed.
    always_comb begin
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        if (valid && state_q != ST_IDLE) begin
            if (control == SYM_DATA) begin
                if (fifo_full || len_q == LW'(MAX_LEN)) begin
                    do_drop = 1'b1;
                end else begin
                    do_write = 1'b1;
                end
            end else if (control == SYM_END && len_q != '0) begin
                do_commit = 1'b1;
            end else begin
                do_drop = 1'b1;
            end
        end
    end

    assign wr_entry = pack_entry(state_q == ST_DLLP, 1'b0, data_dm);

    always_ff @(posedge clk_250k) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            pkt_err_q <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_err_q <= do_drop;
            if (do_drop && err_cnt_q != 8'hff) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (do_commit) begin
                pkt_cnt_q <= pkt_cnt_q + 8'd1;
            end
            if (do_drop || do_commit) begin
                state_q <= ST_IDLE;
                len_q   <= '0;
            end else if (do_write) begin
                len_q <= len_q + LW'(1);
            end else if (valid && state_q == ST_IDLE) begin
                if (control == SYM_STP) begin
                    state_q <= ST_TLP;
                end else if (control == SYM_SDP) begin
                    state_q <= ST_DLLP;
                end
            end
        end
    end

    rx_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_250k),
        .reset_i    (reset),
        .wr_en_i    (do_write),
        .wr_entry_i (wr_entry),
        .commit_i   (do_commit),
        .rewind_i   (do_drop),
        .rd_en_i    (out_ready),
        .full_o     (fifo_full),
        .rd_valid_o (out_valid),
        .rd_entry_o (rd_entry)
    );

    assign out_data    = rd_entry[7:0];
    assign out_last    = rd_entry[LAST_BIT];
    assign out_type    = rd_entry[TYPE_BIT];
    assign pkt_err     = pkt_err_q;
    assign pkt_count   = pkt_cnt_q;
    assign err_count   = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule
